// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared types and default constants for the LED scan controller.
//   scan_state_t  : period stepping direction (DOWN always present, UP only
//                   meaningful when LED_SCAN_PINGPONG_EN is defined)
//   LS_*          : default parameter values for led_scan_ctrl
package led_scan_pkg;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } scan_state_t;

  localparam int LS_CNT_W      = 18;
  localparam int LS_SEL_W      = 2;
  localparam int LS_MAX_PERIOD = 5;
  localparam int LS_MIN_PERIOD = 1;

endpackage : led_scan_pkg

// File: rtl/led_scan_ctrl_rise_detect.sv
// rise_detect: single-flop rising-edge detector for the timer tick.
//   clkSignal : clock, all state on its rising edge
//   RST       : asynchronous active-high reset
//   d         : level or pulse input (timer clkFinish)
//   rise      : high while d is high and was low on the previous edge
// tick_q samples d every cycle regardless of any enable, so a level that is
// already high when the consumer starts listening never looks like an edge.
module rise_detect (
  input  logic clkSignal,
  input  logic RST,
  input  logic d,
  output logic rise
);

  logic tick_d;
  logic tick_q;

  // Next-state for the delayed copy of d.
  always_comb begin
    tick_d = d;
  end

  // Delay register for edge detection.
  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign rise = d & ~tick_q;

endmodule : rise_detect

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: steps a LED select on every timer tick and, after each full
// scan, steps the timer period fed back to the timer.
//   clkSignal  : clock
//   RST        : asynchronous active-high reset
//   EN         : advance enable, 0 freezes all state (tick edges are dropped)
//   tick       : timer clkFinish, rising edge counted
//   maxCount   : period to the timer
//   led_sel    : current LED index
//   led_onehot : one-hot decode of led_sel
//   cycleDone  : one-cycle pulse when led_sel wraps to 0
//   timerRST   : one-cycle pulse when maxCount changes
// Build option: define LED_SCAN_PINGPONG_EN for a bouncing period
// (MAX..MIN..MAX); otherwise the period is a sawtooth (MAX..MIN, reload MAX).
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int CNT_W      = LS_CNT_W,
  parameter int SEL_W      = LS_SEL_W,
  parameter int MAX_PERIOD = LS_MAX_PERIOD,
  parameter int MIN_PERIOD = LS_MIN_PERIOD
) (
  input  logic                  clkSignal,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  tick,
  output logic [CNT_W-1:0]      maxCount,
  output logic [SEL_W-1:0]      led_sel,
  output logic [(2**SEL_W)-1:0] led_onehot,
  output logic                  cycleDone,
  output logic                  timerRST
);

  localparam int NUM_LEDS = 2**SEL_W;
  localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [SEL_W-1:0] SEL_TOP = {SEL_W{1'b1}};

  logic                tick_rise_s;
  logic                event_s;

  logic [SEL_W-1:0]    sel_d,        sel_q;
  logic [NUM_LEDS-1:0] onehot_d,     onehot_q;
  logic [CNT_W-1:0]    period_d,     period_q;
  logic                cycle_done_d, cycle_done_q;
  logic                timer_rst_d,  timer_rst_q;
  scan_state_t         state_d,      state_q;

  rise_detect u_rise_detect (
    .clkSignal (clkSignal),
    .RST       (RST),
    .d         (tick),
    .rise      (tick_rise_s)
  );

  // Edges seen while disabled are simply lost, never queued.
  assign event_s = tick_rise_s & EN;

  // Select counter, period stepper and pulse generation.
  always_comb begin
    sel_d        = sel_q;
    period_d     = period_q;
    state_d      = state_q;
    cycle_done_d = 1'b0;
    timer_rst_d  = 1'b0;
    if (event_s) begin
      sel_d = sel_q + SEL_W'(1);
      if (sel_q == SEL_TOP) begin
        cycle_done_d = 1'b1;
`ifdef LED_SCAN_PINGPONG_EN
        // Turning around at a bound steps immediately in the new direction;
        // every step is guarded so MIN == MAX leaves the period untouched.
        case (state_q)
          DOWN: begin
            if (period_q > MIN_P) begin
              period_d = period_q - CNT_W'(1);
            end else begin
              state_d = UP;
              if (period_q < MAX_P) begin
                period_d = period_q + CNT_W'(1);
              end else begin
                period_d = period_q;
              end
            end
          end
          UP: begin
            if (period_q < MAX_P) begin
              period_d = period_q + CNT_W'(1);
            end else begin
              state_d = DOWN;
              if (period_q > MIN_P) begin
                period_d = period_q - CNT_W'(1);
              end else begin
                period_d = period_q;
              end
            end
          end
          default: begin
            state_d  = DOWN;
            period_d = MAX_P;
          end
        endcase
`else
        // Sawtooth: only the DOWN state exists, so state_q stays constant.
        state_d = state_q;
        if (period_q > MIN_P) begin
          period_d = period_q - CNT_W'(1);
        end else begin
          period_d = MAX_P;
        end
`endif
        timer_rst_d = (period_d != period_q);
      end else begin
        cycle_done_d = 1'b0;
      end
    end else begin
      sel_d = sel_q;
    end
    // Decode from the next select so the registered one-hot tracks led_sel.
    onehot_d = NUM_LEDS'(1) << sel_d;
  end

  // State and registered outputs.
  always_ff @(posedge clkSignal or posedge RST) begin
    if (RST) begin
      sel_q        <= '0;
      onehot_q     <= NUM_LEDS'(1);
      period_q     <= MAX_P;
      cycle_done_q <= 1'b0;
      timer_rst_q  <= 1'b0;
      state_q      <= DOWN;
    end else begin
      sel_q        <= sel_d;
      onehot_q     <= onehot_d;
      period_q     <= period_d;
      cycle_done_q <= cycle_done_d;
      timer_rst_q  <= timer_rst_d;
      state_q      <= state_d;
    end
  end

  assign maxCount   = period_q;
  assign led_sel    = sel_q;
  assign led_onehot = onehot_q;
  assign cycleDone  = cycle_done_q;
  assign timerRST   = timer_rst_q;

endmodule : led_scan_ctrl

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: directed self-checking bench for led_scan_ctrl with the
// default parameters. Expected period sequences follow the build option
// LED_SCAN_PINGPONG_EN.
module tb_led_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        tick;
  logic [17:0] max_count;
  logic [1:0]  led_sel;
  logic [3:0]  led_onehot;
  logic        cycle_done;
  logic        timer_rst;

  int checks   = 0;
  int failures = 0;

`ifdef LED_SCAN_PINGPONG_EN
  localparam int N_WRAPS = 9;
  int wrap_tbl [N_WRAPS] = '{4, 3, 2, 1, 2, 3, 4, 5, 4};
`else
  localparam int N_WRAPS = 5;
  int wrap_tbl [N_WRAPS] = '{4, 3, 2, 1, 5};
`endif

  led_scan_ctrl dut (
    .clkSignal  (clk),
    .RST        (rst),
    .EN         (en),
    .tick       (tick),
    .maxCount   (max_count),
    .led_sel    (led_sel),
    .led_onehot (led_onehot),
    .cycleDone  (cycle_done),
    .timerRST   (timer_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle tick pulse; checks outputs right after the counting edge and
  // that both pulses drop one cycle later. Leaves 10 cycles between ticks.
  task automatic do_tick(input int esel, input int emax, input bit ewrap);
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << esel;
    @(negedge clk) tick = 1'b1;
    @(posedge clk) #1;
    check("sel", 32'(led_sel), 32'(esel));
    check("onehot", 32'(led_onehot), 32'(exp_oh));
    check("maxcount", 32'(max_count), 32'(emax));
    check("cycledone", 32'(cycle_done), 32'(ewrap));
    check("timerrst", 32'(timer_rst), 32'(ewrap));
    @(negedge clk) tick = 1'b0;
    @(posedge clk) #1;
    check("cycledone_drop", 32'(cycle_done), 32'(0));
    check("timerrst_drop", 32'(timer_rst), 32'(0));
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cur_max;
    int esel;
    bit wrap;
    rst  = 1'b1;
    en   = 1'b0;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_sel", 32'(led_sel), 32'(0));
    check("rst_onehot", 32'(led_onehot), 32'(1));
    check("rst_maxcount", 32'(max_count), 32'(5));
    check("rst_cycledone", 32'(cycle_done), 32'(0));
    check("rst_timerrst", 32'(timer_rst), 32'(0));

    // Select stepping plus full period sequence
    en = 1'b1;
    cur_max = 5;
    for (int i = 0; i < 4 * N_WRAPS; i++) begin
      esel = (i + 1) % 4;
      wrap = (esel == 0);
      if (wrap) cur_max = wrap_tbl[i / 4];
      do_tick(esel, cur_max, wrap);
    end

    // EN=0: tick pulses dropped
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("hold_sel", 32'(led_sel), 32'(0));
    check("hold_maxcount", 32'(max_count), 32'(cur_max));

    // tick held high 50 cycles, EN rises mid-pulse: not counted
    @(negedge clk) tick = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);
    check("en_midpulse_sel", 32'(led_sel), 32'(0));
    tick = 1'b0;
    repeat (3) @(negedge clk);

    // 30-cycle pulse with EN=1: exactly one increment
    tick = 1'b1;
    repeat (30) @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    check("long_pulse_sel", 32'(led_sel), 32'(1));
    check("long_pulse_onehot", 32'(led_onehot), 32'(2));

    // Async reset mid-scan at led_sel=2, maxCount=3
    apply_reset();
    cur_max = 5;
    for (int i = 0; i < 10; i++) begin
      esel = (i + 1) % 4;
      wrap = (esel == 0);
      if (wrap) cur_max = wrap_tbl[i / 4];
      do_tick(esel, cur_max, wrap);
    end
    check("pre_arst_sel", 32'(led_sel), 32'(2));
    check("pre_arst_maxcount", 32'(max_count), 32'(3));
    @(posedge clk) #2;
    rst = 1'b1;
    #1;
    check("arst_sel", 32'(led_sel), 32'(0));
    check("arst_onehot", 32'(led_onehot), 32'(1));
    check("arst_maxcount", 32'(max_count), 32'(5));
    check("arst_cycledone", 32'(cycle_done), 32'(0));
    check("arst_timerrst", 32'(timer_rst), 32'(0));
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    do_tick(1, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_scan_ctrl

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Sequencing stage downstream of `timer`: consumes its `clkFinish` tick, steps a 2-bit LED select through all positions and, after each full scan, steps the timer's period (`maxCount`) fed back to the timer. It closes the timer → LED-select → period loop as synthesizable RTL, so the timer plus this block form the complete display-scan controller.

## Interface
- `CNT_W`, 18: width of `maxCount`; matches timer.
- `SEL_W`, 2: width of `led_sel`; `NUM_LEDS = 2**SEL_W`.
- `MAX_PERIOD`, 5: period loaded at reset and on reload.
- `MIN_PERIOD`, 1: smallest period emitted; require `1 <= MIN_PERIOD <= MAX_PERIOD < 2**CNT_W`.
- `clkSignal`  in  1  clock; one clock, all state on its rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `EN`  in  1  advance enable; 0 freezes all state.
- `tick`  in  1  timer `clkFinish`; level or pulse, rising edge counted.
- `maxCount`  out  CNT_W  period to timer.
- `led_sel`  out  SEL_W  current LED index.
- `led_onehot`  out  NUM_LEDS  one-hot decode of `led_sel`.
- `cycleDone`  out  1  one-cycle pulse when `led_sel` wraps to 0.
- `timerRST`  out  1  one-cycle pulse when `maxCount` changes; drives timer restart.

## Operation
- Rising-edge detect: `tick_q` registers `tick` every cycle, including when `EN=0`. Event = `tick & ~tick_q & EN`. Edges while `EN=0` are dropped, not queued. A `tick` already high when `EN` rises is not counted.
- On event: `led_sel <= led_sel + 1`, modulo `NUM_LEDS`.
- On event with `led_sel == NUM_LEDS-1` (wrap):
  - `cycleDone` pulses.
  - Period steps per the state machine.
  - `timerRST` pulses iff the new `maxCount` differs from the old.
- Period state machine (state register from the package enum):
  - DOWN: if `maxCount > MIN_PERIOD`, decrement. Otherwise reload `MAX_PERIOD`, or go to UP when `PINGPONG_EN` is defined.
  - UP (`PINGPONG_EN` only): if `maxCount < MAX_PERIOD`, increment; otherwise decrement and go to DOWN.
- Arithmetic in CNT_W unsigned; bounds checks precede update, so no underflow or overflow is possible.
- `MAX_PERIOD == MIN_PERIOD`: `maxCount` constant; `timerRST` never asserts; `cycleDone` still pulses.
- Reset values: `led_sel=0`, `led_onehot=1`, `maxCount=MAX_PERIOD`, `cycleDone=0`, `timerRST=0`, state DOWN, `tick_q=0`.

## Timing
- Event sampled at rising edge k.
- `led_sel`, `led_onehot`, `maxCount`, `cycleDone` and `timerRST` are all registered and take their new values after edge k; one-cycle latency from `tick` high to output.
- `cycleDone` and `timerRST` high exactly one cycle, coincident with the wrapped `led_sel=0` and the new `maxCount`.
- `led_onehot` always equals the decode of `led_sel` in the same cycle; never zero, never multi-hot.
- `RST` mid-operation clears all state immediately (asynchronously); the first event after release needs a fresh `tick` rising edge.
- A `tick` held high for many cycles counts once.

## Configuration
- `LED_SCAN_PINGPONG_EN` defined:
  - UP state is compiled in.
  - Period bounces 5,4,3,2,1,2,3,4,5,4,… (defaults).
- Undefined:
  - Sawtooth 5,4,3,2,1,5,4,…
  - UP state and direction logic are absent.
  - State register has one value and is optimized away.

## Structure
- Package `led_scan_pkg`:
  - `scan_state_t` enum {DOWN, UP}.
  - Default constants `LS_CNT_W=18`, `LS_MAX_PERIOD=5`, `LS_MIN_PERIOD=1`.
- Sub-module `rise_detect`:
  - Ports `clkSignal`, `RST`, `d`, `rise`.
  - Contains `tick_q`; instantiated once.
- Period stepper and select counter stay in the top module.

## Test plan
- Reset check: assert `RST` then release → `led_sel=0`, `led_onehot=4'b0001`, `maxCount=5`, both pulses 0.
- Select stepping: 4 `tick` pulses (1 cycle each, 10 apart), `EN=1` →
  - `led_sel` goes 1,2,3,0.
  - `cycleDone` and `timerRST` one cycle each at the wrap.
  - `maxCount` becomes 4.
- Sawtooth (macro undefined): 20 ticks → `maxCount` goes 4,3,2,1,5 at wraps; `timerRST` pulses on all 5 wraps.
- Ping-pong (macro defined): 36 ticks → `maxCount` wrap sequence 4,3,2,1,2,3,4,5,4.
- Hold and enable: with `EN=0`, `tick` pulses cause no change. Then `tick` held high for 50 cycles with `EN` rising mid-pulse → no count. A 30-cycle pulse with `EN=1` → exactly one increment.
- Async reset mid-scan: `RST` pulsed between clock edges at `led_sel=2`, `maxCount=3` → outputs return to reset values before the next clock edge.
